// File: rtl/pong_pkg.sv
// Shared screen geometry, colour constants, FSM states and pixel record
// for the pong plot path.
package pong_pkg;

   localparam int         SCREEN_W = 160;
   localparam int         SCREEN_H = 120;
   localparam logic [2:0] BLACK    = 3'b000;
   localparam logic [2:0] WHITE    = 3'b111;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_e;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pix_t;

   function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
      return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
   endfunction

endpackage

// File: rtl/screen_sweep.sv
// Raster counter for the clear sweep: x is the inner loop, y the outer.
// start forces (0,0) and wins over en; the counter wraps to (0,0) after the last pixel.
module screen_sweep
   import pong_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       en,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y
);

   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (start) begin
         x_d = '0;
         y_d = '0;
      end else if (en) begin
         if (x_q == 8'(SCREEN_W - 1)) begin
            x_d = '0;
            y_d = (y_q == 7'(SCREEN_H - 1)) ? '0 : y_q + 7'd1;
         end else begin
            x_d = x_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign done = (x_q == 8'(SCREEN_W - 1)) && (y_q == 7'(SCREEN_H - 1));
   assign x    = x_q;
   assign y    = y_q;

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates ball/paddle pixel writes onto one VGA write port, with a full-screen
// clear sweep after reset or clear_req. Define PLOT_CLIP_EN to drop off-screen requests.
module plot_arbiter
   import pong_pkg::*;
#(
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
)(
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear_req,
   input  logic [7:0] ball_x,
   input  logic [6:0] ball_y,
   input  logic [2:0] ball_colour,
   input  logic       ball_valid,
   output logic       ball_ready,
   input  logic [7:0] pad_x,
   input  logic [6:0] pad_y,
   input  logic [2:0] pad_colour,
   input  logic       pad_valid,
   output logic       pad_ready,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   state_e     state_q, state_d;
   logic       rr_pad_q, rr_pad_d;   // 1: paddle wins the next contended cycle
   pix_t       vga_q, vga_d;
   logic       plot_q, plot_d;
   logic       sweep_px_q, sweep_px_d;
   logic       sw_done;
   logic [7:0] sw_x;
   logic [6:0] sw_y;
   logic       grant_ball, grant_pad;
   pix_t       acc_px;

   screen_sweep u_sweep (
      .clock  (clock),
      .resetn (resetn),
      .start  (clear_req),
      .en     (state_q == SWEEP),
      .done   (sw_done),
      .x      (sw_x),
      .y      (sw_y)
   );

   always_comb begin
      grant_ball = 1'b0;
      grant_pad  = 1'b0;
      if (state_q == RUN) begin
         if (ball_valid && pad_valid) begin
            grant_ball = !rr_pad_q;
            grant_pad  = rr_pad_q;
         end else begin
            grant_ball = ball_valid;
            grant_pad  = pad_valid;
         end
      end
   end

   assign acc_px = grant_ball ? pix_t'{ball_x, ball_y, ball_colour}
                              : pix_t'{pad_x, pad_y, pad_colour};

`ifdef PLOT_CLIP_EN
   logic [7:0] drop_q, drop_d;
   logic       drop_now;

   assign drop_now = (grant_ball || grant_pad) && !on_screen(acc_px.x, acc_px.y);

   always_comb begin
      drop_d = drop_q;
      if (drop_now && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) drop_q <= '0;
      else         drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`else
   logic drop_now;
   assign drop_now = 1'b0;
   assign drop_cnt = 8'd0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_pad_d   = rr_pad_q;
      vga_d      = vga_q;
      plot_d     = 1'b0;
      sweep_px_d = 1'b0;
      case (state_q)
         SWEEP: begin
            vga_d      = '{x: sw_x, y: sw_y, colour: CLEAR_COLOUR};
            plot_d     = 1'b1;
            sweep_px_d = 1'b1;
            rr_pad_d   = 1'b0;
            if (sw_done && !clear_req)
               state_d = RUN;
         end
         RUN: begin
            if (ball_valid && pad_valid)
               rr_pad_d = !rr_pad_q;
            // A request granted alongside clear_req is still plotted before the sweep.
            if ((grant_ball || grant_pad) && !drop_now) begin
               vga_d  = acc_px;
               plot_d = 1'b1;
            end
            if (clear_req)
               state_d = SWEEP;
         end
         default: state_d = SWEEP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= SWEEP;
         rr_pad_q   <= 1'b0;
         vga_q      <= '0;
         plot_q     <= 1'b0;
         sweep_px_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_pad_q   <= rr_pad_d;
         vga_q      <= vga_d;
         plot_q     <= plot_d;
         sweep_px_q <= sweep_px_d;
      end
   end

   assign ball_ready = grant_ball;
   assign pad_ready  = grant_pad;
   assign vga_x      = vga_q.x;
   assign vga_y      = vga_q.y;
   assign vga_colour = vga_q.colour;
   assign vga_plot   = plot_q;
   // Busy covers the sweep state plus the final sweep pixel still on the output.
   assign busy       = (state_q == SWEEP) || sweep_px_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: sweep checks, a grant vector table,
// and a plot scoreboard for the one-cycle write latency.
module tb_plot_arbiter;

   logic       clock = 1'b0;
   logic       resetn, clear_req;
   logic [7:0] ball_x, pad_x;
   logic [6:0] ball_y, pad_y;
   logic [2:0] ball_colour, pad_colour;
   logic       ball_valid, pad_valid;
   logic       ball_ready, pad_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot, busy;
   logic [7:0] drop_cnt;

   always #5 clock = ~clock;

   plot_arbiter dut (
      .clock(clock), .resetn(resetn), .clear_req(clear_req),
      .ball_x(ball_x), .ball_y(ball_y), .ball_colour(ball_colour),
      .ball_valid(ball_valid), .ball_ready(ball_ready),
      .pad_x(pad_x), .pad_y(pad_y), .pad_colour(pad_colour),
      .pad_valid(pad_valid), .pad_ready(pad_ready),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } px_t;

   typedef struct {
      logic       bv;
      logic [7:0] bx;
      logic [6:0] by;
      logic [2:0] bc;
      logic       pv;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
      logic       exp_br;
      logic       exp_pr;
   } vec_t;

   int  checks = 0;
   int  errors = 0;
   px_t sb[$];
   bit  sb_en = 0;
   px_t last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock; with the scoreboard enabled every cycle either pops a plot or must be idle.
   task automatic tick();
      @(posedge clock);
      #1;
      if (sb_en) begin
         if (sb.size() > 0) begin
            px_t e;
            e = sb.pop_front();
            chk("plot_strobe", 32'(vga_plot), 32'd1);
            chk("plot_x", 32'(vga_x), 32'(e.x));
            chk("plot_y", 32'(vga_y), 32'(e.y));
            chk("plot_colour", 32'(vga_colour), 32'(e.c));
            last = e;
         end else begin
            chk("idle_strobe", 32'(vga_plot), 32'd0);
            chk("hold_x", 32'(vga_x), 32'(last.x));
            chk("hold_y", 32'(vga_y), 32'(last.y));
         end
      end
   endtask

   task automatic drive(input vec_t v, input logic clr, input string tag);
      px_t e;
      ball_valid = v.bv; ball_x = v.bx; ball_y = v.by; ball_colour = v.bc;
      pad_valid  = v.pv; pad_x  = v.px; pad_y  = v.py; pad_colour  = v.pc;
      clear_req  = clr;
      #1;
      chk({tag, "_ball_ready"}, 32'(ball_ready), 32'(v.exp_br));
      chk({tag, "_pad_ready"}, 32'(pad_ready), 32'(v.exp_pr));
      if (v.exp_br) e = '{v.bx, v.by, v.bc};
      else          e = '{v.px, v.py, v.pc};
      if (v.exp_br || v.exp_pr) begin
`ifdef PLOT_CLIP_EN
         if (e.x < 8'd160 && e.y < 7'd120) sb.push_back(e);
`else
         sb.push_back(e);
`endif
      end
      tick();
      ball_valid = 0;
      pad_valid  = 0;
      clear_req  = 0;
   endtask

   // Expects 19200 sweep pixels starting at the next sample, then an idle cycle.
   task automatic sweep_check(input bit hold_valids, input string tag);
      int bad = 0;
      int first_bad = -1;
      ball_valid = hold_valids;
      pad_valid  = hold_valids;
      for (int i = 0; i < 19200; i++) begin
         bit ok;
         tick();
         ok = (vga_plot === 1'b1) && (vga_x === 8'(i % 160)) && (vga_y === 7'(i / 160))
              && (vga_colour === 3'b000) && (busy === 1'b1);
         if (i < 19199) ok = ok && (ball_ready === 1'b0) && (pad_ready === 1'b0);
         if (!ok) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
         if (i == 19198) begin
            ball_valid = 0;
            pad_valid  = 0;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sweep_%s bad_cycles=%0d first_bad_index=%0d expected_bad=0", tag, bad, first_bad);
      end
      tick();
      chk({"sweep_end_plot_", tag}, 32'(vga_plot), 32'd0);
      chk({"sweep_end_busy_", tag}, 32'(busy), 32'd0);
   endtask

   vec_t tbl[11];
   vec_t v;

   initial begin
      //         bv  bx     by     bc    pv  px     py     pc    br  pr
      tbl[0]  = '{1, 8'd10,  7'd20,  3'd1, 1, 8'd30,  7'd40, 3'd2, 1, 0};
      tbl[1]  = '{1, 8'd11,  7'd21,  3'd1, 1, 8'd31,  7'd41, 3'd2, 0, 1};
      tbl[2]  = '{1, 8'd12,  7'd22,  3'd1, 1, 8'd32,  7'd42, 3'd2, 1, 0};
      tbl[3]  = '{1, 8'd13,  7'd23,  3'd1, 1, 8'd33,  7'd43, 3'd2, 0, 1};
      tbl[4]  = '{0, 8'd0,   7'd0,   3'd0, 1, 8'd70,  7'd80, 3'd3, 0, 1};
      tbl[5]  = '{0, 8'd0,   7'd0,   3'd0, 0, 8'd0,   7'd0,  3'd0, 0, 0};
      tbl[6]  = '{1, 8'd159, 7'd119, 3'd5, 0, 8'd0,   7'd0,  3'd0, 1, 0};
      tbl[7]  = '{1, 8'd0,   7'd0,   3'd6, 1, 8'd1,   7'd1,  3'd4, 1, 0};
      tbl[8]  = '{0, 8'd0,   7'd0,   3'd0, 1, 8'd159, 7'd0,  3'd7, 0, 1};
      tbl[9]  = '{1, 8'd2,   7'd3,   3'd1, 1, 8'd4,   7'd5,  3'd2, 0, 1};
      tbl[10] = '{1, 8'd6,   7'd7,   3'd3, 1, 8'd8,   7'd9,  3'd4, 1, 0};

      resetn = 0; clear_req = 0;
      ball_valid = 1; pad_valid = 1;
      ball_x = 0; ball_y = 0; ball_colour = 0;
      pad_x = 0; pad_y = 0; pad_colour = 0;
      repeat (3) tick();
      chk("rst_plot", 32'(vga_plot), 32'd0);
      chk("rst_x", 32'(vga_x), 32'd0);
      chk("rst_y", 32'(vga_y), 32'd0);
      chk("rst_colour", 32'(vga_colour), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ball_ready", 32'(ball_ready), 32'd0);
      ball_valid = 0; pad_valid = 0;
      resetn = 1;
      sweep_check(0, "boot");

      sb_en = 1;
      last = '{8'd159, 7'd119, 3'd0};
      v = '{1, 8'd65, 7'd1, 3'b111, 0, 8'd0, 7'd0, 3'd0, 1, 0};
      drive(v, 0, "ball_alone");

      for (int i = 0; i < 11; i++) drive(tbl[i], 0, $sformatf("vec%0d", i));
      tick();

      // Paddle accepted together with clear_req: its pixel goes out before the sweep.
      v = '{0, 8'd0, 7'd0, 3'd0, 1, 8'd10, 7'd116, 3'd3, 0, 1};
      drive(v, 1, "pad_clear");
      sb_en = 0;
      sweep_check(1, "clear");

      sb_en = 1;
      last = '{8'd159, 7'd119, 3'd0};
      v = '{1, 8'd50, 7'd50, 3'd1, 1, 8'd60, 7'd60, 3'd2, 1, 0};
      drive(v, 0, "rr_after_sweep");

`ifdef PLOT_CLIP_EN
      v = '{1, 8'd170, 7'd5, 3'd2, 0, 8'd0, 7'd0, 3'd0, 1, 0};
      drive(v, 0, "clip_x");
      chk("drop_after_1", 32'(drop_cnt), 32'd1);
      v = '{0, 8'd0, 7'd0, 3'd0, 1, 8'd10, 7'd125, 3'd2, 0, 1};
      drive(v, 0, "clip_y");
      chk("drop_after_2", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 298; i++) begin
         ball_x = 8'd170; ball_y = 7'd5; ball_valid = 1;
         tick();
      end
      ball_valid = 0;
      chk("drop_saturated", 32'(drop_cnt), 32'd255);
`else
      v = '{1, 8'd170, 7'd5, 3'd2, 0, 8'd0, 7'd0, 3'd0, 1, 0};
      drive(v, 0, "offscreen_plot");
      chk("drop_const", 32'(drop_cnt), 32'd0);
`endif

      // Reset in the middle of a sweep restarts it from the origin.
      drive('{0, 8'd0, 7'd0, 3'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0}, 1, "clear2");
      sb_en = 0;
      for (int i = 0; i <= 9640; i++) tick();
      chk("mid_plot", 32'(vga_plot), 32'd1);
      chk("mid_x", 32'(vga_x), 32'd40);
      chk("mid_y", 32'(vga_y), 32'd60);
      resetn = 0;
      tick();
      chk("mid_rst_plot", 32'(vga_plot), 32'd0);
      chk("mid_rst_x", 32'(vga_x), 32'd0);
      chk("mid_rst_y", 32'(vga_y), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      tick();
      chk("mid_rst_plot2", 32'(vga_plot), 32'd0);
      resetn = 1;
      sweep_check(0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
